// File: rtl/approx_mult_controller_pkg.sv
// ---------------------------------------------------------------------------
// approx_mult_controller_pkg
// Purpose : shared definitions for the approximate-multiplier control FSM.
//           Holds the state encoding, the normalization guard width and its
//           limit, and a small helper used to derive the busy indication.
// Ports   : none (package).
// ---------------------------------------------------------------------------
package approx_mult_controller_pkg;

  // State register type and encoding. Plain constants keep the encoding
  // stable and readable in legacy tools and waveform viewers.
  typedef logic [2:0] state_t;

  localparam state_t S_IDLE   = 3'd0;
  localparam state_t S_LOAD   = 3'd1;
  localparam state_t S_NORM_A = 3'd2;
  localparam state_t S_NORM_B = 3'd3;
  localparam state_t S_MULT   = 3'd4;
  localparam state_t S_DENORM = 3'd5;
  localparam state_t S_DONE   = 3'd6;
  localparam state_t S_ZERO   = 3'd7;

  // Normalization guard: an operand that has not reached MSB=1 after
  // GUARD_MAX left shifts is treated as zero.
  localparam int                GUARD_W   = 4;
  localparam logic [GUARD_W-1:0] GUARD_MAX = 4'd15;

  // The controller is busy in every state except IDLE.
  function automatic logic state_is_busy(input state_t s);
    return (s != S_IDLE);
  endfunction

endpackage

// File: rtl/approx_mult_controller.sv
// ---------------------------------------------------------------------------
// approx_mult_controller
// Purpose : control FSM for a normalize / 8x8 multiply / denormalize
//           approximate multiplier. Both 16-bit operands are shifted left
//           until their MSB is set (counting shifts up in a shared 5-bit
//           counter), the top bytes are multiplied, and the product is then
//           shifted right by the same total count. An operand that never
//           normalizes within 15 shifts is zero, and the run finishes early
//           with zero_flag set.
// Ports   :
//   clk        in   clock, rising edge
//   rst        in   asynchronous active-high reset
//   start      in   operation request, honoured only in IDLE
//   DoneA      in   MSB of operand-A shift register
//   DoneB      in   MSB of operand-B shift register
//   down_done  in   shift counter equals zero
//   loadA/B    out  load operand registers from the buses
//   ShlA/B     out  shift operand register left by one
//   rst5       out  synchronous clear of the shift counter
//   cntU/cntD  out  increment / decrement the shift counter
//   loadOut    out  capture the 8x8 product
//   ShrOut     out  shift result register right by one
//   busy       out  operation in progress
//   done       out  one-cycle completion pulse
//   zero_flag  out  valid with done: result forced to zero
// ---------------------------------------------------------------------------
module approx_mult_controller
  import approx_mult_controller_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic DoneA,
  input  logic DoneB,
  input  logic down_done,
  output logic loadA,
  output logic loadB,
  output logic ShlA,
  output logic ShlB,
  output logic rst5,
  output logic cntU,
  output logic cntD,
  output logic loadOut,
  output logic ShrOut,
  output logic busy,
  output logic done,
  output logic zero_flag
);

  state_t               r_state;
  state_t               w_state_next;
  logic [GUARD_W-1:0]   r_guard;
  logic [GUARD_W-1:0]   w_guard_next;

  // State and guard registers. Because every output is decoded from
  // r_state, the asynchronous reset clears all outputs immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_guard <= '0;
    end else begin
      r_state <= w_state_next;
      r_guard <= w_guard_next;
    end
  end

  // Next-state and strobe decode. Strobes are Mealy-style on the status
  // inputs so the datapath acts on the same edge that the FSM decides.
  always_comb begin
    w_state_next = r_state;
    w_guard_next = r_guard;
    loadA        = 1'b0;
    loadB        = 1'b0;
    ShlA         = 1'b0;
    ShlB         = 1'b0;
    rst5         = 1'b0;
    cntU         = 1'b0;
    cntD         = 1'b0;
    loadOut      = 1'b0;
    ShrOut       = 1'b0;
    done         = 1'b0;
    zero_flag    = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_state_next = S_LOAD;
        end
      end

      S_LOAD: begin
        loadA        = 1'b1;
        loadB        = 1'b1;
        rst5         = 1'b1;
        w_guard_next = '0;
        w_state_next = S_NORM_A;
      end

      // MSB test takes priority over the guard limit, so an operand whose
      // only set bit is bit 0 still normalizes after exactly 15 shifts.
      S_NORM_A: begin
        if (DoneA) begin
          w_guard_next = '0;
          w_state_next = S_NORM_B;
        end else if (r_guard < GUARD_MAX) begin
          ShlA         = 1'b1;
          cntU         = 1'b1;
          w_guard_next = r_guard + 1'b1;
        end else begin
          w_state_next = S_ZERO;
        end
      end

      S_NORM_B: begin
        if (DoneB) begin
          w_guard_next = '0;
          w_state_next = S_MULT;
        end else if (r_guard < GUARD_MAX) begin
          ShlB         = 1'b1;
          cntU         = 1'b1;
          w_guard_next = r_guard + 1'b1;
        end else begin
          w_state_next = S_ZERO;
        end
      end

      S_MULT: begin
        loadOut      = 1'b1;
        w_state_next = S_DENORM;
      end

      // Undo the total normalization shift one bit per cycle.
      S_DENORM: begin
        if (!down_done) begin
          ShrOut = 1'b1;
          cntD   = 1'b1;
        end else begin
          w_state_next = S_DONE;
        end
      end

      S_DONE: begin
        done         = 1'b1;
        w_state_next = S_IDLE;
      end

      S_ZERO: begin
        done         = 1'b1;
        zero_flag    = 1'b1;
        w_state_next = S_IDLE;
      end

      default: begin
        w_state_next = S_IDLE;
        w_guard_next = '0;
      end
    endcase
  end

  // DONE and ZERO always return through IDLE, so a start held high is
  // re-sampled only after one idle cycle.
  assign busy = state_is_busy(r_state);

endmodule
